// File: rtl/wired_lane_resolver_if.sv
// rtl/wired_lane_resolver_if.sv - input/output stream bundle for the wired lane resolver
interface wired_lane_resolver_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 30
);
    // producer side: one word of LANES drivers plus the net semantic
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_val;
    logic [LANES*WIDTH-1:0]   in_en;
    logic [1:0]               in_mode;

    // consumer side: 4-state resolved word split into value / x / z planes
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_val;
    logic [WIDTH-1:0]         out_unk;
    logic [WIDTH-1:0]         out_z;

    // master drives words in and takes results out
    modport master (
        output in_valid, in_val, in_en, in_mode, out_ready,
        input  in_ready, out_valid, out_val, out_unk, out_z
    );

    // slave is the resolver itself
    modport slave (
        input  in_valid, in_val, in_en, in_mode, out_ready,
        output in_ready, out_valid, out_val, out_unk, out_z
    );
endinterface

// File: rtl/wired_lane_resolver.sv
// rtl/wired_lane_resolver.sv - multi-lane wired-net resolver with stage register and output FIFO (option macro: WIRED_LANE_RESOLVER_CONFLICT_CNT_EN)
module wired_lane_resolver #(
    parameter int LANES      = 4,
    parameter int WIDTH      = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wired_lane_resolver_if.slave  port_io
`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
    ,
    output logic [15:0]           conflict_cnt_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] MODE_TRI    = 2'd0;
    localparam logic [1:0] MODE_TRIAND = 2'd1;
    localparam logic [1:0] MODE_TRIOR  = 2'd2;
    localparam logic [1:0] MODE_TRI0   = 2'd3;

    // stage register: one word plus its latched mode
    logic                   stage_valid_q, stage_valid_d;
    logic [LANES*WIDTH-1:0] stage_val_q,   stage_val_d;
    logic [LANES*WIDTH-1:0] stage_en_q,    stage_en_d;
    logic [1:0]             stage_mode_q,  stage_mode_d;

    // output FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem_val_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_unk_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_z_q   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // per-bit lane summaries and resolved planes of the staged word
    logic [WIDTH-1:0] any_en;
    logic [WIDTH-1:0] any_one;
    logic [WIDTH-1:0] any_zero;
    logic [WIDTH-1:0] res_val;
    logic [WIDTH-1:0] res_unk;
    logic [WIDTH-1:0] res_z;

    // handshake strobes
    logic fifo_not_empty;
    logic accept;
    logic pop;
    logic push;

    assign fifo_not_empty = (count_q != '0);
    assign pop            = fifo_not_empty && port_io.out_ready;
    // the stage may only move on if the FIFO has room now or frees a slot this cycle
    assign push           = stage_valid_q && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);
    assign port_io.in_ready = !rst_i && (!stage_valid_q || push);
    assign accept         = port_io.in_valid && port_io.in_ready;

    // head of FIFO drives the outputs; planes read as zero while empty
    assign port_io.out_valid = fifo_not_empty;
    assign port_io.out_val   = fifo_not_empty ? mem_val_q[rd_ptr_q] : '0;
    assign port_io.out_unk   = fifo_not_empty ? mem_unk_q[rd_ptr_q] : '0;
    assign port_io.out_z     = fifo_not_empty ? mem_z_q[rd_ptr_q]   : '0;

    // collapse all lanes into "someone drives", "someone drives 1", "someone drives 0"
    always_comb begin
        any_en   = '0;
        any_one  = '0;
        any_zero = '0;
        for (int l = 0; l < LANES; l++) begin
            any_en   = any_en   |  stage_en_q[l*WIDTH +: WIDTH];
            any_one  = any_one  | (stage_en_q[l*WIDTH +: WIDTH] &  stage_val_q[l*WIDTH +: WIDTH]);
            any_zero = any_zero | (stage_en_q[l*WIDTH +: WIDTH] & ~stage_val_q[l*WIDTH +: WIDTH]);
        end
    end

    // apply the latched net semantic; value plane is already zero where unk or z is set
    always_comb begin
        res_val = '0;
        res_unk = '0;
        res_z   = '0;
        case (stage_mode_q)
            MODE_TRIAND: begin
                res_z   = ~any_en;
                res_val = any_en & ~any_zero;
            end
            MODE_TRIOR: begin
                res_z   = ~any_en;
                res_val = any_one;
            end
            MODE_TRI0: begin
                // undriven pulls to 0 instead of floating
                res_unk = any_one & any_zero;
                res_val = any_one & ~any_zero;
            end
            default: begin
                res_z   = ~any_en;
                res_unk = any_one & any_zero;
                res_val = any_one & ~any_zero;
            end
        endcase
    end

    // stage next state: capture on accept, empty when it drains into the FIFO
    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_val_d   = stage_val_q;
        stage_en_d    = stage_en_q;
        stage_mode_d  = stage_mode_q;
        if (accept) begin
            stage_valid_d = 1'b1;
            stage_val_d   = port_io.in_val;
            stage_en_d    = port_io.in_en;
            stage_mode_d  = port_io.in_mode;
        end else if (push) begin
            stage_valid_d = 1'b0;
        end
    end

    // FIFO pointer and occupancy next state; simultaneous push and pop keep the count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // control registers; reset drops the staged word and everything queued
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_valid_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // datapath registers need no reset: they are qualified by the valid/count state
    always_ff @(posedge clk_i) begin
        stage_val_q  <= stage_val_d;
        stage_en_q   <= stage_en_d;
        stage_mode_q <= stage_mode_d;
        if (push) begin
            mem_val_q[wr_ptr_q] <= res_val;
            mem_unk_q[wr_ptr_q] <= res_unk;
            mem_z_q[wr_ptr_q]   <= res_z;
        end
    end

`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    // count pushed words carrying any x bit, saturating at all-ones
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (push && (|res_unk) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // conflict counter register, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_q <= 16'd0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_wired_lane_resolver.sv
// tb/tb_wired_lane_resolver.sv - scoreboard bench for wired_lane_resolver (LANES=4, WIDTH=8, FIFO_DEPTH=4)
module tb_wired_lane_resolver;

    localparam int LANES      = 4;
    localparam int WIDTH      = 8;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [23:0] exp_q [$];
    logic [23:0] exp_w;

    wired_lane_resolver_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
    logic [15:0] cnt;
`endif

    wired_lane_resolver #(
        .LANES(LANES), .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .port_io (bus)
`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
        ,
        .conflict_cnt_o (cnt)
`endif
    );

    always #5 clk = ~clk;

    // reference: count enabled ones and zeros per bit, then apply the net rule
    function automatic logic [23:0] model(input logic [31:0] v, input logic [31:0] e, input logic [1:0] m);
        logic [7:0] rv, ru, rz;
        int n0, n1;
        rv = '0; ru = '0; rz = '0;
        for (int b = 0; b < 8; b++) begin
            n0 = 0; n1 = 0;
            for (int l = 0; l < 4; l++) begin
                if (e[l*8+b]) begin
                    if (v[l*8+b]) n1++; else n0++;
                end
            end
            if (n0 + n1 == 0) begin
                if (m != 2'd3) rz[b] = 1'b1;
            end else if (m == 2'd1) begin
                rv[b] = (n0 == 0);
            end else if (m == 2'd2) begin
                rv[b] = (n1 > 0);
            end else if (n0 > 0 && n1 > 0) begin
                ru[b] = 1'b1;
            end else begin
                rv[b] = (n1 > 0);
            end
        end
        return {rv, ru, rz};
    endfunction

    // scoreboard consumer: every word leaving the DUT must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got val=%h unk=%h z=%h want no output", bus.out_val, bus.out_unk, bus.out_z);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bus.out_val, bus.out_unk, bus.out_z} !== exp_w) begin
                    bad++;
                    $display("FAIL sb_word got val=%h unk=%h z=%h want val=%h unk=%h z=%h",
                             bus.out_val, bus.out_unk, bus.out_z, exp_w[23:16], exp_w[15:8], exp_w[7:0]);
                end
            end
        end
    end

    // offer one word starting #1 after a rising edge; returns #1 after the accepting edge
    task automatic put(input logic [31:0] v, input logic [31:0] e, input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_val = v; bus.in_en = e; bus.in_mode = m;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                exp_q.push_back(model(v, e, m));
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL put_timeout got in_ready=0 want 1"); end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain got pending=%0d out_valid=%b want 0 0", exp_q.size(), bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_val !== 8'h00 ||
            bus.out_unk !== 8'h00 || bus.out_z !== 8'h00) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b val=%h unk=%h z=%h want 0 0 00 00 00",
                     bus.in_ready, bus.out_valid, bus.out_val, bus.out_unk, bus.out_z);
        end
`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
        total++;
        if (cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got %h want 0000", cnt); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        put(32'h000000A5, 32'h000000FF, 2'd0);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early got out_valid=%b want 0", bus.out_valid); end
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_val !== 8'hA5 || bus.out_unk !== 8'h00 || bus.out_z !== 8'h00) begin
            bad++;
            $display("FAIL single_word got vld=%b val=%h unk=%h z=%h want 1 a5 00 00",
                     bus.out_valid, bus.out_val, bus.out_unk, bus.out_z);
        end
        drain();
    endtask

    task automatic test_conflict();
        @(posedge clk); #1;
`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
        total++;
        if (cnt !== 16'd0) begin bad++; $display("FAIL conflict_cnt_start got %h want 0000", cnt); end
`endif
        put(32'h00005AA5, 32'h00000FFF, 2'd0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_val !== 8'hA0 || bus.out_unk !== 8'h0F || bus.out_z !== 8'h00) begin
            bad++;
            $display("FAIL conflict_word got vld=%b val=%h unk=%h z=%h want 1 a0 0f 00",
                     bus.out_valid, bus.out_val, bus.out_unk, bus.out_z);
        end
`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
        total++;
        if (cnt !== 16'd1) begin bad++; $display("FAIL conflict_cnt_step got %h want 0001", cnt); end
`endif
        drain();
`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 32'h10000; k++) put(32'h00005AA5, 32'h00000FFF, 2'd0);
        drain();
        total++;
        if (cnt !== 16'hFFFF) begin bad++; $display("FAIL conflict_cnt_sat got %h want ffff", cnt); end
`endif
    endtask

    task automatic test_wired();
        logic [1:0] modes [2] = '{2'd1, 2'd2};
        logic [7:0] want  [2] = '{8'h00, 8'hFF};
`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
        logic [15:0] c0;
        c0 = cnt;
`endif
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            put(32'hFFF00FFF, 32'hFFFFFFFF, modes[i]);
            @(negedge clk);
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_val !== want[i] || bus.out_unk !== 8'h00 || bus.out_z !== 8'h00) begin
                bad++;
                $display("FAIL wired_mode%0d got vld=%b val=%h unk=%h z=%h want 1 %h 00 00",
                         modes[i], bus.out_valid, bus.out_val, bus.out_unk, bus.out_z, want[i]);
            end
            drain();
        end
`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
        total++;
        if (cnt !== c0) begin bad++; $display("FAIL wired_cnt got %h want %h", cnt, c0); end
`endif
    endtask

    task automatic test_undriven();
        logic [1:0] modes [3] = '{2'd0, 2'd3, 2'd1};
        logic [7:0] want_z[3] = '{8'hFF, 8'h00, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            put(32'h12345678, 32'h00000000, modes[i]);
            @(negedge clk);
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_val !== 8'h00 || bus.out_unk !== 8'h00 || bus.out_z !== want_z[i]) begin
                bad++;
                $display("FAIL undriven_mode%0d got vld=%b val=%h unk=%h z=%h want 1 00 00 %h",
                         modes[i], bus.out_valid, bus.out_val, bus.out_unk, bus.out_z, want_z[i]);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int nxt;
        int acc;
        nxt = 1; acc = 0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_val = 32'(nxt); bus.in_en = 32'h000000FF; bus.in_mode = 2'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (acc == 5) begin
                total++;
                if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready cycle=%0d got %b want 0", c, bus.in_ready); end
            end
            if (bus.in_ready) begin
                exp_q.push_back(model(32'(nxt), 32'h000000FF, 2'd0));
                nxt++; acc++;
            end
            @(posedge clk); #1;
            bus.in_val = 32'(nxt);
        end
        total++;
        if (acc != 5) begin bad++; $display("FAIL bp_accept_count got %0d want 5", acc); end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_val !== 8'(j + 1)) begin
                bad++;
                $display("FAIL bp_order slot=%0d got vld=%b val=%h want 1 %h", j, bus.out_valid, bus.out_val, 8'(j + 1));
            end
            if (j == 1) begin
                total++;
                if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return got %b want 1", bus.in_ready); end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(32'(nxt), 32'h000000FF, 2'd0));
                nxt++;
            end
            @(posedge clk); #1;
            if (nxt <= 7) bus.in_val = 32'(nxt); else bus.in_valid = 1'b0;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, e;
        logic [1:0]  m;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            v = $urandom;
            e = $urandom;
            m = 2'($urandom_range(0, 3));
            put(v, e, m);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) put(32'h00000F10 | 32'(k), 32'h00000FFF, 2'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
`ifdef WIRED_LANE_RESOLVER_CONFLICT_CNT_EN
        total++;
        if (cnt !== 16'd0) begin bad++; $display("FAIL midreset_cnt got %h want 0000", cnt); end
`endif
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_leak cycle=%0d got val=%h want no output", c, bus.out_val); end
        end
        @(posedge clk); #1;
        put(32'h0000003C, 32'h000000FF, 2'd3);
        drain();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_val    = '0;
        bus.in_en     = '0;
        bus.in_mode   = 2'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_conflict();
        test_wired();
        test_undriven();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
